mem_stall_ctrl: RTL

Sequencing controller between the pipeline MEM stage and a slow, handshaked data memory. It replaces the single-cycle data memory access. When the MEM stage presents a load or store, the block launches a req/ack transaction and freezes the whole pipeline through `stall_o` until the access completes. It then returns load data and releases the pipeline for exactly one advance cycle. It also provides a timeout abort, a sticky error flag and a stall-cycle counter for performance checks.

---
 rtl/mem_stall_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_stall_ctrl.sv
// Stalls the pipeline around a req/ack data-memory access, with timeout abort,
// sticky error flag and a saturating stall-cycle counter.
module mem_stall_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] ToLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic                access;
  logic                timeout_hit;
  logic [CntW-1:0]     to_cnt_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic [31:0]         stall_cnt_q;

  assign access      = MemRead_i | MemWrite_i;
  assign timeout_hit = (to_cnt_q == ToLast);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (access) state_d = StBusy;
      StBusy:  if (mem_ack_i || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // DONE deliberately ignores the still-visible request so it is not re-issued.
  always_comb begin
    stall_o = 1'b0;
    unique case (state_q)
      StIdle:  stall_o = access;
      StBusy:  stall_o = 1'b1;
      StDone:  stall_o = 1'b0;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access) begin
            mem_addr_q  <= addr_i;
            mem_wdata_q <= data_i;
            mem_we_q    <= MemWrite_i;
            mem_req_q   <= 1'b1;
            to_cnt_q    <= '0;
            if (MemRead_i && MemWrite_i) err_q <= 1'b1;
          end
        end
        StBusy: begin
          // Ack takes priority over a simultaneous timeout.
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) data_q <= mem_rdata_i;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (!mem_we_q) data_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign data_o      = data_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
